// File: rtl/sphincs_hmsg_digest.sv
// SPHINCS+-SHA2 H_msg digest: MGF1-SHA-256(R || PK.seed || SHA-256(R || PK.seed || PK.root || M)).
// Build macro SPHINCS_HMSG_MIDSTATE_EN caches compress(IV, R || seed || inner) across MGF1 counters.

module RTL_crypto_hashblocks_sha256 (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start_in,
   input  logic [255:0] state_in,
   input  logic [511:0] block_in,
   output logic         valid_out,
   output logic [255:0] digest_out
);
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic [255:0] v, init, cur_v, nv, sum;
   logic [511:0] w, cur_w, nw;
   logic [5:0]   rnd, idx;
   logic         run;
   logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, w16;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Round 0 runs on the start edge straight from the inputs, so valid_out lands 64 cycles after start_in.
   always_comb begin
      cur_v = start_in ? state_in : v;
      cur_w = start_in ? block_in : w;
      idx   = start_in ? 6'd0 : rnd;
      {a, b, c, d, e, f, g, h} = cur_v;
      t1  = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[idx] + cur_w[511:480];
      t2  = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      nv  = {t1 + t2, a, b, c, d + t1, e, f, g};
      w16 = (rotr(cur_w[63:32], 17) ^ rotr(cur_w[63:32], 19) ^ (cur_w[63:32] >> 10)) + cur_w[223:192]
          + (rotr(cur_w[479:448], 7) ^ rotr(cur_w[479:448], 18) ^ (cur_w[479:448] >> 3)) + cur_w[511:480];
      nw  = {cur_w[479:0], w16};
      for (int i = 0; i < 8; i++) sum[i*32 +: 32] = init[i*32 +: 32] + nv[i*32 +: 32];
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         run        <= 1'b0;
         rnd        <= '0;
         valid_out  <= 1'b0;
         digest_out <= '0;
      end else begin
         valid_out <= 1'b0;
         if (start_in || run) begin
            v   <= nv;
            w   <= nw;
            rnd <= idx + 6'd1;
         end
         if (start_in) begin
            init <= state_in;
            run  <= 1'b1;
         end else if (run && rnd == 6'd63) begin
            run        <= 1'b0;
            valid_out  <= 1'b1;
            digest_out <= sum;
         end
      end
   end
endmodule

module sphincs_hmsg_digest #(
   parameter int MGF_BLOCKS = 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic [127:0]              r_in,
   input  logic [127:0]              pk_seed,
   input  logic [127:0]              pk_root,
   input  logic [263:0]              msg,
   output logic                      busy,
   output logic [256*MGF_BLOCKS-1:0] digest,
   output logic                      valid
);
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef enum logic [3:0] {IDLE, H0, H0_W, H1, H1_W, M0, M0_W, M1, M1_W, DONE} state_t;
   state_t state;

   logic [127:0]              r_q, seed_q, root_q;
   logic [263:0]              msg_q;
   logic [255:0]              chain, inner;
   logic [256*MGF_BLOCKS-1:0] t_buf, t_next;
   logic [31:0]               ctr;
   logic                      core_start, core_valid, last;
   logic [255:0]              core_state, core_digest;
   logic [511:0]              core_block;

   RTL_crypto_hashblocks_sha256 u_core (
      .CLK        (CLK),
      .RST        (~RST),
      .start_in   (core_start),
      .state_in   (core_state),
      .block_in   (core_block),
      .valid_out  (core_valid),
      .digest_out (core_digest)
   );

   always_comb begin
      core_start = (state == H0) || (state == H1) || (state == M0) || (state == M1);
      core_state = IV;
      core_block = {r_q, seed_q, root_q, msg_q[263:136]};
      case (state)
         H1: begin
            core_state = chain;
            core_block = {msg_q[135:0], 8'h80, 304'd0, 64'h288};
         end
         M0: core_block = {r_q, seed_q, inner};
         M1: begin
            core_state = chain;
            core_block = {ctr, 8'h80, 408'd0, 64'h220};
         end
         default: ;
      endcase
      t_next = t_buf;
      t_next[(MGF_BLOCKS - 1 - int'(ctr)) * 256 +: 256] = core_digest;
      last = (ctr == 32'(MGF_BLOCKS - 1));
   end

   // chain holds compress(IV, IB0) during the inner hash, then compress(IV, MB0) for MGF1.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         busy   <= 1'b0;
         valid  <= 1'b0;
         digest <= '0;
         ctr    <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               r_q    <= r_in;
               seed_q <= pk_seed;
               root_q <= pk_root;
               msg_q  <= msg;
               ctr    <= '0;
               busy   <= 1'b1;
               state  <= H0;
            end
            H0:   state <= H0_W;
            H0_W: if (core_valid) begin
               chain <= core_digest;
               state <= H1;
            end
            H1:   state <= H1_W;
            H1_W: if (core_valid) begin
               inner <= core_digest;
               state <= M0;
            end
            M0:   state <= M0_W;
            M0_W: if (core_valid) begin
               chain <= core_digest;
               state <= M1;
            end
            M1:   state <= M1_W;
            M1_W: if (core_valid) begin
               t_buf <= t_next;
               if (last) begin
                  digest <= t_next;
                  valid  <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else begin
                  ctr <= ctr + 32'd1;
`ifdef SPHINCS_HMSG_MIDSTATE_EN
                  state <= M1;
`else
                  state <= M0;
`endif
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sphincs_hmsg_digest.sv
// Bench for sphincs_hmsg_digest: byte-level SHA-256/MGF1 reference model feeding a scoreboard of digests and valid cycles.
module tb_sphincs_hmsg_digest;
   localparam int MB = 2;
   localparam int TC = 64;
`ifdef SPHINCS_HMSG_MIDSTATE_EN
   localparam int NRUNS = 3 + MB;
`else
   localparam int NRUNS = 2 + 2 * MB;
`endif
   localparam int LAT = 1 + NRUNS * (TC + 1);

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         start = 1'b0;
   logic [127:0] r_in = '0, pk_seed = '0, pk_root = '0;
   logic [263:0] msg = '0;
   logic         busy, valid;
   logic [511:0] digest;

   sphincs_hmsg_digest #(.MGF_BLOCKS(MB)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .start   (start),
      .r_in    (r_in),
      .pk_seed (pk_seed),
      .pk_root (pk_root),
      .msg     (msg),
      .busy    (busy),
      .digest  (digest),
      .valid   (valid)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [511:0] dig;
      int           cyc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int core_starts = 0;
   always @(negedge CLK) if (dut.core_start) core_starts++;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha256(input byte unsigned m[$]);
      byte unsigned p[$];
      logic [63:0]  bl;
      logic [31:0]  hv [8];
      logic [31:0]  wv [64];
      logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh, x1, x2;
      hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      p  = m;
      bl = 64'(m.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
      for (int blk = 0; blk < p.size() / 64; blk++) begin
         for (int t = 0; t < 16; t++)
            wv[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
         for (int t = 16; t < 64; t++)
            wv[t] = (rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
                  + (rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
         {va, vb, vc, vd, ve, vf, vg, vh} = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
         for (int t = 0; t < 64; t++) begin
            x1 = vh + (rr(ve, 6) ^ rr(ve, 11) ^ rr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + KT[t] + wv[t];
            x2 = (rr(va, 2) ^ rr(va, 13) ^ rr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
            vh = vg; vg = vf; vf = ve; ve = vd + x1;
            vd = vc; vc = vb; vb = va; va = x1 + x2;
         end
         hv[0] += va; hv[1] += vb; hv[2] += vc; hv[3] += vd;
         hv[4] += ve; hv[5] += vf; hv[6] += vg; hv[7] += vh;
      end
      return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
   endfunction

   // MGF1-SHA-256 over R || seed || SHA-256(R || seed || root || M), T(0) in the top 256 bits.
   function automatic logic [767:0] hmsg(input logic [127:0] r, s, rt, input logic [263:0] m, input int nb);
      byte unsigned q[$];
      logic [647:0] d;
      logic [543:0] mm;
      logic [255:0] inr;
      logic [767:0] res;
      d = {r, s, rt, m};
      for (int i = 80; i >= 0; i--) q.push_back(d[i*8 +: 8]);
      inr = sha256(q);
      res = '0;
      for (int c = 0; c < nb; c++) begin
         q.delete();
         mm = {r, s, inr, 32'(c)};
         for (int i = 67; i >= 0; i--) q.push_back(mm[i*8 +: 8]);
         res[767 - 256*c -: 256] = sha256(q);
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (!RST && valid) begin
         chk("valid_expected", 512'(sb.size() > 0), 512'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("digest", digest, e.dig);
            chk("valid_cycle", 512'(cyc), 512'(e.cyc));
            chk("busy_at_valid", 512'(busy), 512'(0));
         end
      end
   end

   task automatic go_to(input int t);
      while (cyc < t) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic start_req(input logic [127:0] r, s, rt, input logic [263:0] m, input bit push, output int acc);
      exp_t         e;
      logic [767:0] full;
      @(posedge CLK);
      #1;
      r_in = r; pk_seed = s; pk_root = rt; msg = m;
      start = 1'b1;
      acc = cyc;
      if (push) begin
         full  = hmsg(r, s, rt, m, MB);
         e.dig = full[767:256];
         e.cyc = acc + LAT;
         sb.push_back(e);
      end
      @(posedge CLK);
      #1;
      start = 1'b0;
      @(negedge CLK);
      chk("busy_after_accept", 512'(busy), 512'(1));
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (sb.size() != 0 && n < maxc) begin
         @(negedge CLK);
         n++;
      end
      chk("done_in_time", 512'(sb.size() == 0), 512'(1));
      sb.delete();
   endtask

   task automatic wait_valid(input int maxc);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!valid && n < maxc);
      chk("valid_seen", 512'(valid), 512'(1));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int           acc, base;
      byte unsigned q[$];
      logic [767:0] full;
      logic [127:0] ra, sa, ta;
      logic [263:0] ma;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_busy", 512'(busy), 512'(0));
      chk("reset_valid", 512'(valid), 512'(0));
      chk("reset_digest", digest, 512'(0));
      RST = 1'b0;

      q = '{8'h61, 8'h62, 8'h63};
      chk("model_abc", 512'(sha256(q)), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
      q.delete();
      chk("model_empty", 512'(sha256(q)), 512'(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855));

      // All-zero known answer.
      start_req('0, '0, '0, '0, 1'b1, acc);
      wait_done(LAT + 20);

      // Byte ordering, core run count and MGF1 prefix property.
      ra = 128'h000102030405060708090a0b0c0d0e0f;
      sa = 128'h101112131415161718191a1b1c1d1e1f;
      ta = 128'h202122232425262728292a2b2c2d2e2f;
      ma = 264'h303132333435363738393a3b3c3d3e3f404142434445464748494a4b4c4d4e4f50;
      base = core_starts;
      start_req(ra, sa, ta, ma, 1'b1, acc);
      wait_done(LAT + 20);
      chk("core_starts", 512'(core_starts - base), 512'(NRUNS));
      full = hmsg(ra, sa, ta, ma, 1);
      chk("mgf1_prefix", 512'(digest[511:256]), 512'(full[767:512]));

      // Random pattern.
      ra = {$urandom, $urandom, $urandom, $urandom};
      sa = {$urandom, $urandom, $urandom, $urandom};
      ta = {$urandom, $urandom, $urandom, $urandom};
      ma = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 8'($urandom)};
      start_req(ra, sa, ta, ma, 1'b1, acc);
      wait_done(LAT + 20);

      // Input changes after accept and a start while busy must have no effect.
      start_req(ra ^ 128'h1, sa, ta, ma, 1'b1, acc);
      go_to(acc + 2);
      r_in = ~r_in; pk_seed = ~pk_seed; pk_root = ~pk_root; msg = ~msg;
      go_to(acc + 10);
      r_in = 128'hdead; start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      wait_done(LAT + 20);

      // A start pulse coinciding with valid is dropped.
      start_req(sa, ta, ra, ma, 1'b1, acc);
      go_to(acc + LAT);
      r_in = 128'hbeef; start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      @(negedge CLK);
      chk("start_at_valid_ignored", 512'(busy), 512'(0));
      wait_done(LAT + 20);

      // Reset in the middle of a request.
      start_req(ra, sa, ta, ma, 1'b0, acc);
      go_to(acc + 100);
      RST = 1'b1;
      start = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      start = 1'b0;
      @(negedge CLK);
      chk("midreset_busy", 512'(busy), 512'(0));
      chk("midreset_valid", 512'(valid), 512'(0));
      chk("midreset_digest", digest, 512'(0));
      repeat (LAT + 40) @(negedge CLK);
      start_req(ta, ra, sa, ~ma, 1'b1, acc);
      wait_done(LAT + 20);

      // Back-to-back: next start lands on the cycle after valid.
      start_req(ra, ra, ra, ma, 1'b1, acc);
      wait_valid(LAT + 20);
      start_req(sa, sa, sa, ma, 1'b1, acc);
      wait_done(LAT + 20);

      repeat (5) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
